reg_sel_decoder: RTL and testbench

REG_SEL_DECODER -- requirements
Module: reg_sel_decoder

---
 rtl/reg_sel_decoder.sv | 126 ++++++++++++
 tb/tb_reg_sel_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_sel_decoder.sv
// ============================================================================
//  Module      : reg_sel_decoder
//  Description : Registered one-hot register-select decoder. It either decodes
//                a single address per accepted request, or sweeps every index
//                0..N-1 in turn. The sweep can be aborted, and index 0 can
//                optionally be a hard-wired zero register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_sel_decoder #(
    parameter int AW      = 5,   // address width, must be >= 1
    parameter int ZERO_EN = 1    // 0: index 0 decodes to an all-zero select
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [AW-1:0]       addr,
    input  logic                abort,
    output logic [(2**AW)-1:0]  sel,
    output logic                sel_valid,
    output logic                busy,
    output logic                sweep_done
);

    localparam int N = 2**AW;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [N-1:0]    sel_q, sel_d;
    logic            sel_valid_q, sel_valid_d;
    logic            last_q, last_d;     // the index now on sel is N-1
    logic [AW-1:0]   idx_inc;

    // One-hot decode of an index; index 0 is optionally a zero register.
    function automatic logic [N-1:0] decode(input logic [AW-1:0] i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        if ((ZERO_EN == 0) && (i == '0)) begin
            r = '0;
        end
        return r;
    endfunction

    assign idx_inc = idx_q + {{(AW-1){1'b0}}, 1'b1};

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        last_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // abort is deliberately ignored here
                if (in_valid) begin
                    if (!mode) begin
                        sel_d       = decode(addr);
                        sel_valid_d = 1'b1;
                    end else begin
                        state_d     = SWEEP;
                        idx_d       = '0;
                        sel_d       = decode('0);
                        sel_valid_d = 1'b1;
                    end
                end
            end
            SWEEP: begin
                if (abort) begin
                    // abort wins over everything, including the final index
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (&idx_q) begin
                    // last index already presented: stop without wrapping
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d       = idx_inc;
                    sel_d       = decode(idx_inc);
                    sel_valid_d = 1'b1;
                    last_d      = &idx_inc;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            last_q      <= last_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SWEEP);
    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    // An abort raised while the last index is showing suppresses the pulse.
    assign sweep_done = last_q & ~abort;

endmodule

`default_nettype wire

// File: tb/tb_reg_sel_decoder.sv
// ============================================================================
//  Module      : tb_reg_sel_decoder
//  Description : Scoreboard bench for reg_sel_decoder. Two instances share the
//                stimulus (ZERO_EN=1 and ZERO_EN=0); a queue of expected
//                outputs, each tagged with its due cycle, is built from the
//                request rules and consumed by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_sel_decoder;

    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          abort = 1'b0;

    logic          in_ready_a, sel_valid_a, busy_a, done_a;
    logic [N-1:0]  sel_a;
    logic          in_ready_b, sel_valid_b, busy_b, done_b;
    logic [N-1:0]  sel_b;

    reg_sel_decoder #(.AW(AW), .ZERO_EN(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .mode(mode), .addr(addr), .abort(abort), .sel(sel_a),
        .sel_valid(sel_valid_a), .busy(busy_a), .sweep_done(done_a)
    );

    reg_sel_decoder #(.AW(AW), .ZERO_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .mode(mode), .addr(addr), .abort(abort), .sel(sel_b),
        .sel_valid(sel_valid_b), .busy(busy_b), .sweep_done(done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;    // cycle in which the output must appear
        int idx;    // index expected on sel
        bit done;   // expected sweep_done
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   rem      = 0;   // sweep cycles still to be shown, current included
    bit   cur_busy = 1'b0;
    bit   mon_en   = 1'b0;
    int   n_chk    = 0;
    int   n_err    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_sel(int idx, bit zero_en);
        if (!zero_en && idx == 0) return 32'd0;
        return 32'd1 << idx;
    endfunction

    // One clock cycle of stimulus; the model decides what gets accepted.
    task automatic step(input logic v, input logic m, input logic [AW-1:0] a,
                        input logic ab);
        cyc++;
        cur_busy = (rem > 0);
        in_valid = v;
        mode     = m;
        addr     = a;
        abort    = ab;
        if (rem > 0) begin
            if (ab) begin
                while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
                if (q.size() > 0) q[$].done = 1'b0;
                rem = 0;
            end else begin
                rem--;
            end
        end else if (v) begin
            if (!m) begin
                q.push_back('{cyc + 1, int'(a), 1'b0});
            end else begin
                for (int k = 0; k < N; k++)
                    q.push_back('{cyc + 1 + k, k, (k == N - 1)});
                rem = N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges, with the sweep discarded.
    task automatic rst_pulse();
        cyc++;
        in_valid = 1'b0;
        mode     = 1'b0;
        abort    = 1'b0;
        rst      = 1'b1;
        q.delete();
        rem      = 0;
        cur_busy = 1'b0;
        #1;
        chk("rst_async_sel",       sel_a,        32'd0);
        chk("rst_async_sel_valid", 32'(sel_valid_a), 32'd0);
        chk("rst_async_busy",      32'(busy_a),  32'd0);
        chk("rst_async_done",      32'(done_a),  32'd0);
        chk("rst_async_in_ready",  32'(in_ready_a), 32'd1);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares both instances against the head of the queue.
    initial begin
        exp_t e;
        logic overdue;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready_a", 32'(in_ready_a), 32'(!cur_busy));
                chk("busy_a",     32'(busy_a),     32'(cur_busy));
                chk("in_ready_b", 32'(in_ready_b), 32'(!cur_busy));
                chk("busy_b",     32'(busy_b),     32'(cur_busy));
                chk("valid_match_b", 32'(sel_valid_b), 32'(sel_valid_a));
                if (sel_valid_a) begin
                    chk("expected_pending", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("due_cycle", 32'(e.cyc), 32'(cyc));
                        chk("sel_a",  sel_a,         ref_sel(e.idx, 1'b1));
                        chk("sel_b",  sel_b,         ref_sel(e.idx, 1'b0));
                        chk("done_a", 32'(done_a),   32'(e.done));
                        chk("done_b", 32'(done_b),   32'(e.done));
                    end
                end else begin
                    chk("idle_sel_a",  sel_a,       32'd0);
                    chk("idle_sel_b",  sel_b,       32'd0);
                    chk("idle_done_a", 32'(done_a), 32'd0);
                    overdue = 1'b0;
                    if (q.size() > 0) overdue = (q[0].cyc <= cyc);
                    chk("overdue_output", 32'(overdue), 32'd0);
                end
            end
        end
    end

    initial begin
        // reset must act before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("reset_sel",       sel_a,              32'd0);
        chk("reset_sel_valid", 32'(sel_valid_a),   32'd0);
        chk("reset_busy",      32'(busy_a),        32'd0);
        chk("reset_done",      32'(done_a),        32'd0);
        chk("reset_in_ready",  32'(in_ready_a),    32'd1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // single decode then idle
        step(1'b1, 1'b0, 5'd7, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);
        // abort in IDLE does not block a request
        step(1'b1, 1'b0, 5'd3, 1'b1);
        // back-to-back decodes
        step(1'b1, 1'b0, 5'd0,  1'b0);
        step(1'b1, 1'b0, 5'd31, 1'b0);
        step(1'b1, 1'b0, 5'd16, 1'b0);
        step(1'b0, 1'b0, 5'd0,  1'b0);

        // full sweep, with requests offered throughout
        step(1'b1, 1'b1, 5'd9, 1'b0);
        for (int i = 0; i < N + 2; i++) step(1'b1, 1'b0, 5'($urandom), 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);

        // abort while index 10 is shown
        step(1'b1, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);

        // abort coincident with the final index
        step(1'b1, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);

        // reset pulse while index 4 is shown, then a fresh decode
        step(1'b1, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
        rst_pulse();
        step(1'b1, 1'b0, 5'd12, 1'b0);
        step(1'b0, 1'b0, 5'd0,  1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 5'($urandom), $urandom_range(0, 19) == 0);
        end

        // drain: the longest outstanding work is one sweep
        for (int i = 0; i < N + 3; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
